// File: rtl/traffic_lights_sequencer.sv
// Host-side sequencer for a traffic_lights controller. It expands START, STOP
// and CONFIG requests into spaced, single-cycle command strobes.
module traffic_lights_sequencer #(
   parameter int CMD_GAP     = 1,
   parameter int MIN_TIME_MS = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  req_op_i,
   input  logic [15:0] req_green_ms_i,
   input  logic [15:0] req_red_ms_i,
   input  logic [15:0] req_yellow_ms_i,
   output logic [2:0]  cmd_type_o,
   output logic        cmd_valid_o,
   output logic [15:0] cmd_data_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam logic [1:0] OP_START  = 2'd0;
   localparam logic [1:0] OP_STOP   = 2'd1;
   localparam logic [1:0] OP_CONFIG = 2'd2;

   localparam logic [2:0] CMD_ON        = 3'd0;
   localparam logic [2:0] CMD_OFF       = 3'd1;
   localparam logic [2:0] CMD_UNREG     = 3'd2;
   localparam logic [2:0] CMD_GREEN_MS  = 3'd3;
   localparam logic [2:0] CMD_RED_MS    = 3'd4;
   localparam logic [2:0] CMD_YELLOW_MS = 3'd5;

   localparam logic        HAS_GAP  = (CMD_GAP > 0);
   localparam int          GAP_W    = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CMD_GAP > 0) ? (CMD_GAP - 1) : 0);
   localparam logic [15:0] MIN_TIME = 16'(MIN_TIME_MS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t             state_r;
   logic [1:0]         op_r;
   logic [15:0]        green_r;
   logic [15:0]        red_r;
   logic [15:0]        yellow_r;
   logic [2:0]         idx_r;
   logic [GAP_W-1:0]   gap_cnt_r;
   logic               cmd_valid_r;
   logic [2:0]         cmd_type_r;
   logic [15:0]        cmd_data_r;
   logic               busy_r;
   logic               err_r;

   logic               accept_s;
   logic               legal_s;
   logic               last_s;
   logic [2:0]         next_idx_s;
   logic [2:0]         first_type_s;
   logic [15:0]        first_data_s;
   logic [2:0]         next_type_s;
   logic [15:0]        next_data_s;

   // Index of the final command in each op's command list.
   function automatic logic [2:0] last_idx_f(input logic [1:0] op);
      logic [2:0] res;
      case (op)
         OP_CONFIG: res = 3'd4;
         default:   res = 3'd0;
      endcase
      return res;
   endfunction

   function automatic logic [2:0] cmd_type_f(input logic [1:0] op, input logic [2:0] idx);
      logic [2:0] res;
      case (op)
         OP_START: res = CMD_ON;
         OP_STOP:  res = CMD_OFF;
         OP_CONFIG: begin
            case (idx)
               3'd0:    res = CMD_UNREG;
               3'd1:    res = CMD_GREEN_MS;
               3'd2:    res = CMD_RED_MS;
               3'd3:    res = CMD_YELLOW_MS;
               default: res = CMD_ON;
            endcase
         end
         default:  res = CMD_ON;
      endcase
      return res;
   endfunction

   // Only the three phase-time commands carry a payload.
   function automatic logic [15:0] cmd_data_f(input logic [1:0] op, input logic [2:0] idx,
                                              input logic [15:0] g, input logic [15:0] r,
                                              input logic [15:0] y);
      logic [15:0] res;
      res = 16'd0;
      if (op == OP_CONFIG) begin
         case (idx)
            3'd1:    res = g;
            3'd2:    res = r;
            3'd3:    res = y;
            default: res = 16'd0;
         endcase
      end else begin
         res = 16'd0;
      end
      return res;
   endfunction

   assign accept_s     = req_valid_i && req_ready_o;
   assign next_idx_s   = idx_r + 3'd1;
   assign last_s       = (idx_r == last_idx_f(op_r));
   assign first_type_s = cmd_type_f(req_op_i, 3'd0);
   assign first_data_s = cmd_data_f(req_op_i, 3'd0, req_green_ms_i, req_red_ms_i, req_yellow_ms_i);
   assign next_type_s  = cmd_type_f(op_r, next_idx_s);
   assign next_data_s  = cmd_data_f(op_r, next_idx_s, green_r, red_r, yellow_r);

   // Request legality: reserved op and too-short CONFIG times are rejected.
   always_comb begin
      legal_s = 1'b0;
      case (req_op_i)
         OP_START, OP_STOP: legal_s = 1'b1;
         OP_CONFIG: legal_s = (req_green_ms_i >= MIN_TIME) &&
                              (req_red_ms_i >= MIN_TIME) &&
                              (req_yellow_ms_i >= MIN_TIME);
         default:   legal_s = 1'b0;
      endcase
   end

   // Sequencer FSM; command outputs are registered and default to zero each cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r     <= ST_IDLE;
         op_r        <= 2'd0;
         green_r     <= 16'd0;
         red_r       <= 16'd0;
         yellow_r    <= 16'd0;
         idx_r       <= 3'd0;
         gap_cnt_r   <= '0;
         cmd_valid_r <= 1'b0;
         cmd_type_r  <= 3'd0;
         cmd_data_r  <= 16'd0;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         cmd_valid_r <= 1'b0;
         cmd_type_r  <= 3'd0;
         cmd_data_r  <= 16'd0;
         err_r       <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s && legal_s) begin
                  op_r        <= req_op_i;
                  green_r     <= req_green_ms_i;
                  red_r       <= req_red_ms_i;
                  yellow_r    <= req_yellow_ms_i;
                  idx_r       <= 3'd0;
                  state_r     <= ST_ISSUE;
                  busy_r      <= 1'b1;
                  cmd_valid_r <= 1'b1;
                  cmd_type_r  <= first_type_s;
                  cmd_data_r  <= first_data_s;
               end else if (accept_s) begin
                  err_r <= 1'b1;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_ISSUE: begin
               if (last_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else if (HAS_GAP) begin
                  state_r   <= ST_GAP;
                  gap_cnt_r <= '0;
               end else begin
                  idx_r       <= next_idx_s;
                  cmd_valid_r <= 1'b1;
                  cmd_type_r  <= next_type_s;
                  cmd_data_r  <= next_data_s;
               end
            end
            ST_GAP: begin
               if (gap_cnt_r == GAP_LAST) begin
                  state_r     <= ST_ISSUE;
                  idx_r       <= next_idx_s;
                  cmd_valid_r <= 1'b1;
                  cmd_type_r  <= next_type_s;
                  cmd_data_r  <= next_data_s;
               end else begin
                  gap_cnt_r <= gap_cnt_r + 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Ready is gated by reset so it reads 0 while reset is held and 1 right after release.
   assign req_ready_o = (state_r == ST_IDLE) && rst_n_i;
   assign cmd_valid_o = cmd_valid_r;
   assign cmd_type_o  = cmd_type_r;
   assign cmd_data_o  = cmd_data_r;
   assign busy_o      = busy_r;
   assign err_o       = err_r;

endmodule

// File: tb/tb_traffic_lights_sequencer.sv
// Randomized bench for traffic_lights_sequencer against a schedule-based reference model.
module tb_traffic_lights_sequencer;

   localparam int GAP = 1;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [1:0]  req_op_i;
   logic [15:0] req_green_ms_i;
   logic [15:0] req_red_ms_i;
   logic [15:0] req_yellow_ms_i;
   logic [2:0]  cmd_type_o;
   logic        cmd_valid_o;
   logic [15:0] cmd_data_o;
   logic        busy_o;
   logic        err_o;

   logic        req_valid0;
   logic        req_ready0;
   logic [2:0]  cmd_type0;
   logic        cmd_valid0;
   logic [15:0] cmd_data0;
   logic        busy0;
   logic        err0;

   traffic_lights_sequencer #(.CMD_GAP(GAP), .MIN_TIME_MS(1)) u_dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_green_ms_i(req_green_ms_i), .req_red_ms_i(req_red_ms_i),
      .req_yellow_ms_i(req_yellow_ms_i),
      .cmd_type_o(cmd_type_o), .cmd_valid_o(cmd_valid_o), .cmd_data_o(cmd_data_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   traffic_lights_sequencer #(.CMD_GAP(0), .MIN_TIME_MS(1)) u_dut0 (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_op_i(req_op_i),
      .req_green_ms_i(req_green_ms_i), .req_red_ms_i(req_red_ms_i),
      .req_yellow_ms_i(req_yellow_ms_i),
      .cmd_type_o(cmd_type0), .cmd_valid_o(cmd_valid0), .cmd_data_o(cmd_data0),
      .busy_o(busy0), .err_o(err0)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [2:0]  typ;
      logic [15:0] dat;
   } ev_t;

   ev_t sched[$];
   int  busy_first = -1;
   int  busy_last  = -1;
   int  err_cyc    = -1;
   int  total      = 0;
   int  bad        = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Command list of a request, independent of any timing.
   task automatic accept(input logic [1:0] op, input logic [15:0] g, input logic [15:0] r,
                         input logic [15:0] y);
      int          n;
      logic [2:0]  tl[5];
      logic [15:0] dl[5];
      n = 0;
      for (int k = 0; k < 5; k++) begin
         tl[k] = 3'd0;
         dl[k] = 16'd0;
      end
      if (op == 2'd0) begin
         n = 1; tl[0] = 3'd0;
      end else if (op == 2'd1) begin
         n = 1; tl[0] = 3'd1;
      end else if (op == 2'd2 && g >= 16'd1 && r >= 16'd1 && y >= 16'd1) begin
         n = 5;
         tl[0] = 3'd2; tl[1] = 3'd3; tl[2] = 3'd4; tl[3] = 3'd5; tl[4] = 3'd0;
         dl[1] = g; dl[2] = r; dl[3] = y;
      end
      if (n == 0) begin
         err_cyc = cyc + 1;
      end else begin
         for (int k = 0; k < n; k++)
            sched.push_back('{cyc: cyc + 1 + k * (GAP + 1), typ: tl[k], dat: dl[k]});
         busy_first = cyc + 1;
         busy_last  = cyc + 1 + (n - 1) * (GAP + 1);
      end
   endtask

   task automatic check_outputs();
      ev_t  e;
      logic ev;
      e  = '{cyc: -1, typ: 3'd0, dat: 16'd0};
      ev = 1'b0;
      if (sched.size() > 0) begin
         if (sched[0].cyc == cyc) begin
            e  = sched.pop_front();
            ev = 1'b1;
         end
      end
      chk("ready", req_ready_o, cyc > busy_last);
      chk("valid", cmd_valid_o, ev);
      chk("type",  cmd_type_o,  e.typ);
      chk("data",  cmd_data_o,  e.dat);
      chk("busy",  busy_o,      (cyc >= busy_first) && (cyc <= busy_last));
      chk("err",   err_o,       cyc == err_cyc);
   endtask

   // Called at a falling edge: check this cycle, drive next inputs, update model.
   task automatic step(input logic v, input logic [1:0] op, input logic [15:0] g,
                       input logic [15:0] r, input logic [15:0] y);
      check_outputs();
      req_valid_i     = v;
      req_op_i        = op;
      req_green_ms_i  = g;
      req_red_ms_i    = r;
      req_yellow_ms_i = y;
      if (v && (cyc > busy_last)) accept(op, g, r, y);
      @(negedge clk_i);
   endtask

   function automatic logic [15:0] rnd_time();
      return ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 60000));
   endfunction

   task automatic check_all_zero(input string tag, input logic exp_ready);
      chk({tag, "_valid"}, cmd_valid_o, 1'b0);
      chk({tag, "_type"},  cmd_type_o,  3'd0);
      chk({tag, "_data"},  cmd_data_o,  16'd0);
      chk({tag, "_busy"},  busy_o,      1'b0);
      chk({tag, "_err"},   err_o,       1'b0);
      chk({tag, "_ready"}, req_ready_o, exp_ready);
   endtask

   initial begin
      rst_n_i         = 1'b0;
      req_valid_i     = 1'b0;
      req_valid0      = 1'b0;
      req_op_i        = 2'd0;
      req_green_ms_i  = 16'd0;
      req_red_ms_i    = 16'd0;
      req_yellow_ms_i = 16'd0;
      #2;
      check_all_zero("rst", 1'b0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      chk("rst_release_ready", req_ready_o, 1'b1);

      // CONFIG 10/20/5 with one-cycle gaps
      step(1'b1, 2'd2, 16'd10, 16'd20, 16'd5);
      for (int i = 0; i < 11; i++) step(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);

      // START then STOP with valid held across the busy window
      step(1'b1, 2'd0, 16'd0, 16'd0, 16'd0);
      for (int i = 0; i < 2; i++) step(1'b1, 2'd1, 16'd0, 16'd0, 16'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);

      // Rejections: red=0 and reserved op
      step(1'b1, 2'd2, 16'd10, 16'd0, 16'd5);
      step(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      step(1'b1, 2'd3, 16'd10, 16'd20, 16'd5);
      for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);

      // Pulse valid while busy: must be dropped
      step(1'b1, 2'd2, 16'd7, 16'd8, 16'd9);
      step(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      step(1'b1, 2'd0, 16'd0, 16'd0, 16'd0);
      for (int i = 0; i < 10; i++) step(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++)
         step(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
              rnd_time(), rnd_time(), rnd_time());
      for (int i = 0; i < 12; i++) step(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);

      // Reset during the GREEN_MS strobe
      step(1'b1, 2'd2, 16'd11, 16'd22, 16'd33);
      step(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      step(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      check_outputs();
      chk("green_before_rst", cmd_type_o, 3'd3);
      rst_n_i = 1'b0;
      #1;
      check_all_zero("async_rst", 1'b0);
      sched.delete();
      busy_first = -1;
      busy_last  = -1;
      err_cyc    = -1;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      chk("ready_after_rst", req_ready_o, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);

      // Zero-gap instance: five strobes on consecutive cycles
      req_valid_i     = 1'b0;
      req_valid0      = 1'b1;
      req_op_i        = 2'd2;
      req_green_ms_i  = 16'd100;
      req_red_ms_i    = 16'd200;
      req_yellow_ms_i = 16'd300;
      @(negedge clk_i);
      req_valid0 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         logic [2:0]  et;
         logic [15:0] ed;
         et = (k == 4) ? 3'd0 : 3'(k + 2);
         ed = (k == 1) ? 16'd100 : (k == 2) ? 16'd200 : (k == 3) ? 16'd300 : 16'd0;
         chk("gap0_valid", cmd_valid0, 1'b1);
         chk("gap0_type",  cmd_type0,  et);
         chk("gap0_data",  cmd_data0,  ed);
         chk("gap0_busy",  busy0,      1'b1);
         chk("gap0_ready", req_ready0, 1'b0);
         @(negedge clk_i);
      end
      chk("gap0_done_valid", cmd_valid0, 1'b0);
      chk("gap0_done_busy",  busy0,      1'b0);
      chk("gap0_done_ready", req_ready0, 1'b1);
      chk("gap0_err",        err0,       1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
